// File: rtl/lsu.sv
// Load/store unit: answers the control unit's en_ls handshake with a fixed-latency
// access to an internal word-addressed data memory and a one-cycle ls_done pulse.
module lsu #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        en_ls,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              ls_done,
  output logic              ls_err
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              store_reg, store_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [DATA_W-1:0] d_out_reg;
  logic              done_reg, err_reg;
  logic              access, err_fire, load_fire, store_fire;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    store_next = store_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    access     = 1'b0;
    err_fire   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en_ls == 2'b01 || en_ls == 2'b10) begin
          store_next = en_ls[1];
          addr_next  = addr;
          data_next  = d_in;
          cnt_next   = CNT_INIT;
          state_next = BUSY;
        end else if (en_ls == 2'b11) begin
          err_fire = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          access     = 1'b1;
          state_next = DONE;
        end
      end
      // A request still held after completion parks in RELEASE so it cannot retrigger.
      DONE:    state_next = (en_ls == 2'b00) ? IDLE : RELEASE;
      RELEASE: if (en_ls == 2'b00) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign load_fire  = access & ~store_reg;
  assign store_fire = access & store_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      store_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      d_out_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      store_reg <= store_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      done_reg  <= access;
      err_reg   <= err_fire;
      if (load_fire) d_out_reg <= mem[addr_reg];
    end
  end

  // Memory is deliberately outside the reset domain; reset forces IDLE so no pending store fires.
  always_ff @(posedge clk) begin
    if (store_fire) mem[addr_reg] <= data_reg;
  end

  assign d_out   = d_out_reg;
  assign ls_done = done_reg;
  assign ls_err  = err_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected completions into a queue that a
// negedge monitor pops and checks whenever ls_done or ls_err is raised.
module tb_lsu;
  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    en_ls = 2'b00;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] d_in = '0;
  logic [DW-1:0] d_out;
  logic          ls_done;
  logic          ls_err;

  lsu #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .en_ls(en_ls), .addr(addr), .d_in(d_in),
    .d_out(d_out), .ls_done(ls_done), .ls_err(ls_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_err;
    logic [DW-1:0] dout;
    string         name;
  } exp_t;

  exp_t          exp_q[$];
  int            n_tests = 0;
  int            n_fail = 0;
  logic [DW-1:0] last_dout = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every completion/error pulse must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && (ls_done || ls_err)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: ls_done=%0b ls_err=%0b with nothing pending", ls_done, ls_err);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_kind"}, {30'd0, ls_err, ls_done}, e.is_err ? 32'd2 : 32'd1);
        check({e.name, "_dout"}, {16'd0, d_out}, {16'd0, e.dout});
        $display("[TB] %s: ls_done=%0b ls_err=%0b d_out=%04h", e.name, ls_done, ls_err, d_out);
      end
    end
  end

  // Issue one load/store; hold en_ls for hold_cycles (0 = drop on ls_done).
  // When chg is set, addr/d_in are altered after the sampling edge.
  task automatic request(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp_load, input string name, input int hold_cycles,
                         input bit chg, input logic [AW-1:0] alt_a, input logic [DW-1:0] alt_d);
    exp_t e;
    int cyc;
    bit seen;
    e.is_err = 1'b0;
    e.dout   = (op == 2'b01) ? exp_load : last_dout;
    e.name   = name;
    exp_q.push_back(e);
    if (op == 2'b01) last_dout = exp_load;
    en_ls = op;
    addr  = a;
    d_in  = d;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (chg && cyc == 1) begin
        addr = alt_a;
        d_in = alt_d;
      end
      if (ls_done) seen = 1'b1;
    end
    check({name, "_latency"}, cyc, LAT + 1);
    while (cyc < hold_cycles) begin
      @(negedge clk);
      cyc++;
    end
    en_ls = 2'b00;
    @(negedge clk);
    check({name, "_pulse_end"}, {31'd0, ls_done}, 32'd0);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    check("reset_d_out", {16'd0, d_out}, 32'd0);
    check("reset_ls_done", {31'd0, ls_done}, 32'd0);
    check("reset_ls_err", {31'd0, ls_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic store then load.
    request(2'b10, 8'h12, 16'hBEEF, 16'h0000, "store_12", 0, 1'b0, 8'h00, 16'h0000);
    request(2'b01, 8'h12, 16'h0000, 16'hBEEF, "load_12", 0, 1'b0, 8'h00, 16'h0000);

    // Held load: exactly one pulse over 6 cycles.
    request(2'b01, 8'h12, 16'h0000, 16'hBEEF, "held_load_12", 6, 1'b0, 8'h00, 16'h0000);

    // Back-to-back at address extremes.
    request(2'b10, 8'h00, 16'h0001, 16'h0000, "store_00", 0, 1'b0, 8'h00, 16'h0000);
    request(2'b10, 8'hFF, 16'hFFFF, 16'h0000, "store_ff", 0, 1'b0, 8'h00, 16'h0000);
    request(2'b01, 8'h00, 16'h0000, 16'h0001, "load_00", 0, 1'b0, 8'h00, 16'h0000);
    request(2'b01, 8'hFF, 16'h0000, 16'hFFFF, "load_ff", 0, 1'b0, 8'h00, 16'h0000);

    // Illegal request held for two cycles: two error pulses, no memory access.
    e.is_err = 1'b1;
    e.dout   = last_dout;
    e.name   = "err_a";
    exp_q.push_back(e);
    e.name   = "err_b";
    exp_q.push_back(e);
    en_ls = 2'b11;
    addr  = 8'h12;
    d_in  = 16'h5A5A;
    @(negedge clk);
    check("err_first", {31'd0, ls_err}, 32'd1);
    @(negedge clk);
    check("err_repeat", {31'd0, ls_err}, 32'd1);
    en_ls = 2'b00;
    @(negedge clk);
    check("err_end", {31'd0, ls_err}, 32'd0);
    request(2'b01, 8'h12, 16'h0000, 16'hBEEF, "load_12_after_err", 0, 1'b0, 8'h00, 16'h0000);

    // Inputs changed during BUSY must be ignored.
    request(2'b10, 8'h34, 16'h5555, 16'h0000, "store_34", 0, 1'b0, 8'h00, 16'h0000);
    request(2'b10, 8'h33, 16'h2222, 16'h0000, "store_33_chg", 0, 1'b1, 8'h34, 16'h1111);
    request(2'b01, 8'h33, 16'h0000, 16'h2222, "load_33", 0, 1'b0, 8'h00, 16'h0000);
    request(2'b01, 8'h34, 16'h0000, 16'h5555, "load_34", 0, 1'b0, 8'h00, 16'h0000);

    // Reset during a store's BUSY: outputs clear, the store never lands.
    request(2'b10, 8'h40, 16'hAAAA, 16'h0000, "store_40", 0, 1'b0, 8'h00, 16'h0000);
    request(2'b01, 8'h40, 16'h0000, 16'hAAAA, "load_40", 0, 1'b0, 8'h00, 16'h0000);
    en_ls = 2'b10;
    addr  = 8'h40;
    d_in  = 16'h1234;
    @(negedge clk);
    reset = 1'b1;
    en_ls = 2'b00;
    #1;
    check("rst_mid_d_out", {16'd0, d_out}, 32'd0);
    check("rst_mid_ls_done", {31'd0, ls_done}, 32'd0);
    check("rst_mid_ls_err", {31'd0, ls_err}, 32'd0);
    last_dout = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    request(2'b01, 8'h40, 16'h0000, 16'hAAAA, "load_40_after_rst", 0, 1'b0, 8'h00, 16'h0000);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the memory-side responder to the control unit's load/store handshake. It accepts a load or store request on `en_ls`, performs the access on an internal word-addressed data memory after a fixed latency, and returns completion on `ls_done`. Load data appears on `d_out`, which the datapath routes into register C. The block sits beside the datapath and is driven directly by the control unit during its FETCH state.

## Interface
- `DATA_W`, 16: data word width.
- `ADDR_W`, 8: address width; memory depth is 2**ADDR_W words.
- `LATENCY`, 2: cycles spent in BUSY before the access happens; legal range ≥1.

- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `en_ls`  in  2: request. 00 = none, 01 = load, 10 = store, 11 = illegal.
- `addr`  in  ADDR_W: word address, sampled with the request.
- `d_in`  in  DATA_W: store data, sampled with the request.
- `d_out`  out  DATA_W: load result, registered.
- `ls_done`  out  1: registered one-cycle completion pulse.
- `ls_err`  out  1: registered one-cycle pulse on an illegal request.

## Operation
- States: IDLE, BUSY, DONE, RELEASE. Encoding is free.
- IDLE:
  - `en_ls` = 01 or 10: latch op, `addr` and `d_in`; set `cnt` to LATENCY-1; go to BUSY.
  - `en_ls` = 11: pulse `ls_err`, stay IDLE, no memory access.
  - `en_ls` = 00: stay IDLE.
- BUSY:
  - `cnt` ≠ 0: decrement `cnt`.
  - `cnt` = 0: perform the access on the latched values and go to DONE.
    - Load: `d_out` <= mem[addr].
    - Store: mem[addr] <= data. `d_out` is unchanged.
- DONE: `ls_done` = 1. Next state is IDLE if `en_ls` = 00, otherwise RELEASE.
- RELEASE: stay until `en_ls` = 00, then go to IDLE. A held request never retriggers.
- Changes to `en_ls`, `addr` or `d_in` during BUSY, DONE or RELEASE are ignored. Only the latched values are used.
- Memory array is not reset. Contents are undefined until written.
- Address space is exactly 2**ADDR_W words, so there is no out-of-range case.

## Timing
- Reset values: `d_out` = 0, `ls_done` = 0, `ls_err` = 0, state = IDLE, `cnt` = 0, latched op/addr/data = 0.
- Request sampled at edge N in IDLE.
  - The access occurs at edge N+LATENCY.
  - `ls_done` is high from edge N+LATENCY to edge N+LATENCY+1.
- Load data is valid on `d_out` whenever `ls_done` = 1 and stays held until the next load completes. The control unit captures it into reg C at edge N+LATENCY+1.
- When the control unit drops `en_ls` in the cycle after `ls_done`, DONE returns to IDLE and the next request can be sampled at edge N+LATENCY+2.
- `ls_err` is high for exactly one cycle after the sampling edge. It repeats every cycle while 11 is held in IDLE.
- Reset asserted mid-operation:
  - All outputs clear immediately.
  - A store whose access edge has not yet occurred never writes.
  - A write already committed is retained.
- Reset deasserted with `en_ls` ≠ 00: the request is sampled at the first clock edge after deassertion.

## Test plan
All scenarios use LATENCY=2.
- Store 0xBEEF to addr 0x12 (en_ls=10 held until `ls_done`) → `ls_done` pulses at edge N+2 for one cycle. Then load addr 0x12 → `d_out` = 0xBEEF while `ls_done` = 1.
- Hold en_ls=01 for 6 cycles at addr 0x12 → exactly one `ls_done` pulse. FSM stays in RELEASE until en_ls=00.
- Back-to-back: store 0x0001 to 0x00, store 0xFFFF to 0xFF, load 0x00, load 0xFF with one idle cycle between → loads return 0x0001 and 0xFFFF, one `ls_done` per request.
- en_ls=11 for one cycle in IDLE → `ls_err` = 1 for one cycle, no `ls_done`, and memory at the current `addr` is unchanged on a later load.
- Change `addr` and `d_in` to 0x34/0x1111 during BUSY of a store to 0x33 with 0x2222 → load 0x33 = 0x2222 and load 0x34 ≠ 0x1111 (still the previously written value).
- Pulse `reset` one cycle after a store request to 0x40 (old value 0xAAAA) → `ls_done`, `d_out` and `ls_err` are 0 immediately, and a later load of 0x40 returns 0xAAAA.
